// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake grid frame scheduler: segment width,
// default sizing constants, the grid cell codes and the scheduler state enum.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int SEG_W       = 8;    // {y[3:0], x[3:0]}
    localparam int NUM_SEG_DEF = 225;  // maximum snake segments
    localparam int CELLS_DEF   = 256;  // 16x16 grid

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_HEAD  = 2'b01,
        CELL_BODY  = 2'b10,
        CELL_FOOD  = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SNAKE,
        ST_FOOD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seg_select.sv
// -----------------------------------------------------------------------------
// seg_select
// Combinational segment mux: returns segment idx ({y, x}) of the packed
// segment vector. Indices at or beyond NUM_SEG return 0.
//   segs : packed segments, segment k = segs[8k+7:8k]
//   idx  : segment index
//   seg  : selected segment {y[3:0], x[3:0]}
// -----------------------------------------------------------------------------
module seg_select
    import snake_pkg::*;
#(
    parameter int NUM_SEG = NUM_SEG_DEF
) (
    input  logic [NUM_SEG*SEG_W-1:0] segs,
    input  logic [7:0]               idx,
    output logic [SEG_W-1:0]         seg
);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        seg = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (idx == 8'(k)) begin
                seg = segs[k*SEG_W +: SEG_W];
            end
        end
    end

endmodule

// File: rtl/grid_frame_scheduler.sv
// -----------------------------------------------------------------------------
// grid_frame_scheduler
// Renders one snake-game frame into a 16x16 grid memory: on a tick it captures
// the snake, its length and the food cell, then writes every cell empty, the
// snake segments (head first) and finally the food cell, one write per
// accepted handshake (we & wr_ready). A tick arriving while busy is remembered
// once and starts the next frame right after the current one finishes.
//   clk, reset        : clock, asynchronous active-low reset
//   tick              : frame-start request
//   snake_in/snake_len: packed segments {y,x} (segment 0 = head), length
//   food_x/food_y     : food cell
//   wr_ready          : grid memory accepts a write this cycle
//   x_loc/y_loc       : cell address, data_out: cell code, we: write request
//   busy              : high outside IDLE, frame_done: one-cycle end pulse
// -----------------------------------------------------------------------------
module grid_frame_scheduler
    import snake_pkg::*;
#(
    parameter int NUM_SEG = NUM_SEG_DEF,
    parameter int CELLS   = CELLS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [NUM_SEG*SEG_W-1:0] snake_in,
    input  logic [7:0]               snake_len,
    input  logic [3:0]               food_x,
    input  logic [3:0]               food_y,
    input  logic                     wr_ready,
    output logic [3:0]               x_loc,
    output logic [3:0]               y_loc,
    output logic [1:0]               data_out,
    output logic                     we,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [7:0] NUM_SEG_L = 8'(NUM_SEG);
    localparam logic [8:0] LAST_CELL = 9'(CELLS - 1);

    state_t                     state_q, state_d;
    logic [8:0]                 count_q, count_d;
    logic                       pend_q, pend_d;
    logic [NUM_SEG*SEG_W-1:0]   snake_q, snake_d;
    logic [7:0]                 len_q, len_d;
    logic [3:0]                 food_x_q, food_x_d;
    logic [3:0]                 food_y_q, food_y_d;
    logic [SEG_W-1:0]           seg;

    seg_select #(.NUM_SEG(NUM_SEG)) u_seg_select (
        .segs (snake_q),
        .idx  (count_q[7:0]),
        .seg  (seg)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_d     = pend_q;
        snake_d    = snake_q;
        len_d      = len_q;
        food_x_d   = food_x_q;
        food_y_d   = food_y_q;
        we         = 1'b0;
        busy       = (state_q != ST_IDLE);
        frame_done = 1'b0;
        x_loc      = '0;
        y_loc      = '0;
        data_out   = CELL_EMPTY;

        // Only one tick is remembered while a frame is in flight.
        if (tick && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end

        // Outputs depend only on registered state, so they hold while stalled.
        case (state_q)
            ST_IDLE: begin
                if (tick || pend_q) begin
                    snake_d  = snake_in;
                    len_d    = (snake_len > NUM_SEG_L) ? NUM_SEG_L : snake_len;
                    food_x_d = food_x;
                    food_y_d = food_y;
                    count_d  = '0;
                    pend_d   = 1'b0;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                we    = 1'b1;
                x_loc = count_q[3:0];
                y_loc = count_q[7:4];
                if (wr_ready) begin
                    if (count_q == LAST_CELL) begin
                        count_d = '0;
                        state_d = (len_q == 8'd0) ? ST_FOOD : ST_SNAKE;
                    end else begin
                        count_d = count_q + 9'd1;
                    end
                end
            end
            ST_SNAKE: begin
                we       = 1'b1;
                x_loc    = seg[3:0];
                y_loc    = seg[7:4];
                data_out = (count_q == 9'd0) ? CELL_HEAD : CELL_BODY;
                if (wr_ready) begin
                    if (count_q + 9'd1 == {1'b0, len_q}) begin
                        count_d = '0;
                        state_d = ST_FOOD;
                    end else begin
                        count_d = count_q + 9'd1;
                    end
                end
            end
            ST_FOOD: begin
                we       = 1'b1;
                x_loc    = food_x_q;
                y_loc    = food_y_q;
                data_out = CELL_FOOD;
                if (wr_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                // A pending tick is serviced by IDLE in the following cycle.
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            pend_q   <= 1'b0;
            // NOTE: the wide shadow registers are reset too, so an aborted frame leaves no stale snake behind.
            snake_q  <= '0;
            len_q    <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state_q  <= state_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            snake_q  <= snake_d;
            len_q    <= len_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
        end
    end

endmodule

// File: tb/tb_grid_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_grid_frame_scheduler
// Scoreboard bench: each frame's expected writes and frame_done are queued
// when the frame is set up; a monitor pops and compares on every accepted
// write or frame_done, and checks that outputs hold across stalls.
// -----------------------------------------------------------------------------
module tb_grid_frame_scheduler;

    typedef struct packed {
        logic       is_done;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] d;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [225*8-1:0] snake_in;
    logic [7:0]       snake_len;
    logic [3:0]       food_x, food_y;
    logic             wr_ready;
    logic [3:0]       x_loc, y_loc;
    logic [1:0]       data_out;
    logic             we, busy, frame_done;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  stall_mode = 1'b0;
    ev_t sb[$];

    grid_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .snake_in   (snake_in),
        .snake_len  (snake_len),
        .food_x     (food_x),
        .food_y     (food_y),
        .wr_ready   (wr_ready),
        .x_loc      (x_loc),
        .y_loc      (y_loc),
        .data_out   (data_out),
        .we         (we),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // wr_ready: constant 1, or toggling 1,0,1,0 while stall_mode is set.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = stall_mode ? ~wr_ready : 1'b1;
        end
    end

    // Monitor / scoreboard.
    ev_t obs, held;
    bit  have, prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && we) begin
                check("hold_x", 32'(x_loc), 32'(held.x));
                check("hold_y", 32'(y_loc), 32'(held.y));
                check("hold_data", 32'(data_out), 32'(held.d));
            end
            prev_stall = we && !wr_ready;
            held       = '{is_done: 1'b0, x: x_loc, y: y_loc, d: data_out};
            have       = 1'b0;
            if (we && wr_ready) begin
                obs  = '{is_done: 1'b0, x: x_loc, y: y_loc, d: data_out};
                have = 1'b1;
            end else if (frame_done) begin
                check("done_we_low", 32'(we), 32'd0);
                obs  = '0;
                obs.is_done = 1'b1;
                have = 1'b1;
            end
            if (have) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got 0x%0h, expected none at %0t", obs, $time);
                end else begin
                    check("sb_event", 32'(obs), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic set_seg(input int k, input logic [3:0] x, input logic [3:0] y);
        snake_in[k*8 +: 8] = {y, x};
    endtask

    // Queue a full frame: 256 clears, nseg snake cells, food, frame_done.
    task automatic push_frame(input int nseg, input logic [3:0] fx, input logic [3:0] fy);
        ev_t        e;
        logic [7:0] s;
        for (int c = 0; c < 256; c++) begin
            e = '{is_done: 1'b0, x: 4'(c), y: 4'(c >> 4), d: 2'b00};
            sb.push_back(e);
        end
        for (int k = 0; k < nseg; k++) begin
            s = snake_in[k*8 +: 8];
            e = '{is_done: 1'b0, x: s[3:0], y: s[7:4], d: (k == 0) ? 2'b01 : 2'b10};
            sb.push_back(e);
        end
        sb.push_back('{is_done: 1'b0, x: fx, y: fy, d: 2'b11});
        e = '0;
        e.is_done = 1'b1;
        sb.push_back(e);
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    // Count negedges until frame_done; the first counted negedge is frame cycle 2.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no frame_done, expected one within 3000 cycles");
    endtask

    task automatic run_frame(input int exp_len, input string name);
        int cyc;
        pulse_tick();
        wait_done(cyc);
        check(name, 32'(cyc + 1), 32'(exp_len));
    endtask

    int cyc;

    initial begin
        reset     = 1'b0;
        tick      = 1'b0;
        snake_in  = '0;
        snake_len = '0;
        food_x    = '0;
        food_y    = '0;

        // Reset state.
        #2;
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_xy", 32'({x_loc, y_loc}), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Basic frame: len 3, (1,1),(2,1),(3,1), food (5,5); unused segments garbage.
        for (int k = 0; k < 225; k++) snake_in[k*8 +: 8] = 8'hEE;
        set_seg(0, 4'd1, 4'd1);
        set_seg(1, 4'd2, 4'd1);
        set_seg(2, 4'd3, 4'd1);
        snake_len = 8'd3;
        food_x = 4'd5;
        food_y = 4'd5;
        push_frame(3, 4'd5, 4'd5);
        run_frame(262, "frame_len_basic");
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);

        // Stalls: wr_ready toggles, len 4.
        set_seg(0, 4'd0, 4'd15);
        set_seg(1, 4'd15, 4'd0);
        set_seg(2, 4'd7, 4'd8);
        set_seg(3, 4'd8, 4'd7);
        snake_len = 8'd4;
        food_x = 4'd0;
        food_y = 4'd0;
        push_frame(4, 4'd0, 4'd0);
        stall_mode = 1'b1;
        pulse_tick();
        wait_done(cyc);
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);

        // len 0: food directly after clear.
        snake_len = 8'd0;
        food_x = 4'd9;
        food_y = 4'd14;
        push_frame(0, 4'd9, 4'd14);
        run_frame(259, "frame_len_zero");

        // len 255 clamps to 225 snake writes; segment k = k.
        for (int k = 0; k < 225; k++) snake_in[k*8 +: 8] = 8'(k);
        snake_len = 8'd255;
        food_x = 4'd3;
        food_y = 4'd12;
        push_frame(225, 4'd3, 4'd12);
        run_frame(484, "frame_len_max");

        // Two ticks mid-frame -> exactly one back-to-back frame with fresh capture.
        for (int k = 0; k < 225; k++) snake_in[k*8 +: 8] = 8'h00;
        set_seg(0, 4'd4, 4'd4);
        set_seg(1, 4'd4, 4'd5);
        set_seg(2, 4'd4, 4'd6);
        snake_len = 8'd3;
        food_x = 4'd10;
        food_y = 4'd10;
        push_frame(3, 4'd10, 4'd10);
        pulse_tick();
        repeat (10) @(posedge clk);
        pulse_tick();
        repeat (3) @(posedge clk);
        pulse_tick();
        set_seg(0, 4'd12, 4'd2);
        set_seg(1, 4'd13, 4'd2);
        set_seg(2, 4'd1, 4'd1);
        snake_len = 8'd2;
        food_x = 4'd6;
        food_y = 4'd7;
        push_frame(2, 4'd6, 4'd7);
        wait_done(cyc);
        @(negedge clk);
        check("b2b_capture_busy", 32'(busy), 32'd0);
        check("b2b_capture_we", 32'(we), 32'd0);
        @(negedge clk);
        check("b2b_first_we", 32'(we), 32'd1);
        check("b2b_first_xy", 32'({x_loc, y_loc}), 32'd0);
        wait_done(cyc);
        check("b2b_second_len", 32'(cyc), 32'd259);
        repeat (5) @(negedge clk);
        check("no_third_frame", 32'(busy), 32'd0);

        // Reset during SNAKE aborts the frame; next tick restarts cleanly.
        for (int k = 0; k < 10; k++) set_seg(k, 4'(k), 4'(15 - k));
        snake_len = 8'd10;
        food_x = 4'd2;
        food_y = 4'd3;
        push_frame(10, 4'd2, 4'd3);
        pulse_tick();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (we && data_out == 2'b01) break;
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_xy", 32'({x_loc, y_loc}), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        snake_len = 8'd2;
        push_frame(2, 4'd2, 4'd3);
        run_frame(261, "frame_len_after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
